// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing a single-port, registered-read data memory.
// Optional bound check (macro MEM_ARB_BOUND_CHECK_EN) adds p0_err/p1_err and blocks addr >= DEPTH.
module mem_arbiter #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 128
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic          mem_write,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_w_data,
    input  logic [DW-1:0] m_r_data,
`ifdef MEM_ARB_BOUND_CHECK_EN
    output logic          p0_err,
    output logic          p1_err,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          own_q, own_d;
    logic          we_q, we_d;
    logic [AW-1:0] m_addr_d;
    logic [DW-1:0] m_w_data_d;
    logic          mem_write_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic          busy_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [DW-1:0] resp_data;

    logic          win;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          win_fault;

`ifdef MEM_ARB_BOUND_CHECK_EN
    logic          fault_q, fault_d;
    logic [1:0]    err_q, err_d;

    // A faulting read returns zero instead of whatever the memory aliased to
    assign resp_data = fault_q ? '0 : m_r_data;
    assign p0_err    = err_q[0];
    assign p1_err    = err_q[1];
`else
    assign resp_data = m_r_data;

    // DEPTH only matters when the bound check is built in
    if (DEPTH == 0) begin : g_depth_unused
    end
`endif

    assign p0_gnt    = gnt_q[0];
    assign p1_gnt    = gnt_q[1];
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    // Read data is live from the memory register during RESP, then held per port
    assign p0_rdata  = rvalid_q[0] ? resp_data : rdata0_q;
    assign p1_rdata  = rvalid_q[1] ? resp_data : rdata1_q;

    // Next-state, winner selection and registered-output decode
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        own_d       = own_q;
        we_d        = we_q;
        m_addr_d    = m_addr;
        m_w_data_d  = m_w_data;
        mem_write_d = 1'b0;
        gnt_d       = 2'b00;
        rvalid_d    = 2'b00;
        busy_d      = busy;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
`ifdef MEM_ARB_BOUND_CHECK_EN
        fault_d     = fault_q;
        err_d       = 2'b00;
`endif

        win       = (p0_req && p1_req) ? rr_ptr_q : p1_req;
        win_we    = win ? p1_we    : p0_we;
        win_addr  = win ? p1_addr  : p0_addr;
        win_wdata = win ? p1_wdata : p0_wdata;
`ifdef MEM_ARB_BOUND_CHECK_EN
        win_fault = (win_addr >= AW'(DEPTH));
`else
        win_fault = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_d     = ACCESS;
                    own_d       = win;
                    we_d        = win_we;
                    m_addr_d    = win_addr;
                    m_w_data_d  = win_wdata;
                    rr_ptr_d    = ~win;
                    mem_write_d = win_we && !win_fault;
                    gnt_d[win]  = 1'b1;
                    busy_d      = 1'b1;
`ifdef MEM_ARB_BOUND_CHECK_EN
                    fault_d     = win_fault;
                    err_d[win]  = win_fault;
`endif
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d         = RESP;
                    rvalid_d[own_q] = 1'b1;
                    busy_d          = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (own_q) begin
                    rdata1_d = resp_data;
                end else begin
                    rdata0_d = resp_data;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            own_q     <= 1'b0;
            we_q      <= 1'b0;
            m_addr    <= '0;
            m_w_data  <= '0;
            mem_write <= 1'b0;
            gnt_q     <= 2'b00;
            rvalid_q  <= 2'b00;
            busy      <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
`ifdef MEM_ARB_BOUND_CHECK_EN
            fault_q   <= 1'b0;
            err_q     <= 2'b00;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            own_q     <= own_d;
            we_q      <= we_d;
            m_addr    <= m_addr_d;
            m_w_data  <= m_w_data_d;
            mem_write <= mem_write_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            busy      <= busy_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
`ifdef MEM_ARB_BOUND_CHECK_EN
            fault_q   <= fault_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic against a transaction-level model of grants and memory contents.
module tb_mem_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          mem_write, busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_w_data, m_r_data;
`ifdef MEM_ARB_BOUND_CHECK_EN
    logic          p0_err, p1_err;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_write(mem_write), .m_addr(m_addr), .m_w_data(m_w_data), .m_r_data(m_r_data),
`ifdef MEM_ARB_BOUND_CHECK_EN
        .p0_err(p0_err), .p1_err(p1_err),
`endif
        .busy(busy)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Single-port memory: write commits on negedge, read data registered on posedge
    logic [DW-1:0] mem [DEPTH];
    bit            mem_init_done = 1'b0;
    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] = init_word(i);
            mem_init_done = 1'b1;
        end else if (mem_write) begin
            mem[m_addr[6:0]] = m_w_data;
        end
    end
    always @(posedge clk) m_r_data <= mem[m_addr[6:0]];

    // Reference model state
    logic [DW-1:0] shadow [DEPTH];
    logic [DW-1:0] last_rd [2];
    int            fav;
    int            vectors = 0;
    int            miscompares = 0;

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input int port, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
        vec_t v;
        v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int port, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic drop_req(input int port);
        if (port == 0) p0_req = 1'b0;
        else           p1_req = 1'b0;
    endtask

    task automatic model_reset();
        fav = 0;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    // Wait for the expected grant, check the access and any read response; updates the model
    task automatic serve(input int port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, output int lat, output logic [DW-1:0] rd);
        int            n;
        logic [DW-1:0] exp_rd;
        n  = 0;
        rd = '0;
        @(negedge clk);
        while (!(p0_gnt || p1_gnt) && n < 6) begin
            chk("idle_before_gnt", 32'({busy, mem_write, p0_rvalid, p1_rvalid}), 32'd0);
            n++;
            @(negedge clk);
        end
        lat = n;
        if (!(p0_gnt || p1_gnt)) begin
            chk("gnt_timeout", 32'(p0_gnt || p1_gnt), 32'd1);
            drop_req(port);
            return;
        end
        chk("gnt_owner", 32'({p1_gnt, p0_gnt}), (port == 0) ? 32'd1 : 32'd2);
        chk("access_busy", 32'(busy), 32'd1);
        chk("access_mem_write", 32'(mem_write), 32'(we));
        chk("access_m_addr", m_addr, addr);
        if (we) chk("access_m_w_data", m_w_data, wdata);
`ifdef MEM_ARB_BOUND_CHECK_EN
        chk("access_err", 32'({p1_err, p0_err}), 32'd0);
`endif
        fav = 1 - port;
        if (we) shadow[addr[6:0]] = wdata;
        @(posedge clk); #1;
        drop_req(port);
        if (!we) begin
            exp_rd = shadow[addr[6:0]];
            @(negedge clk);
            chk("resp_rvalid", 32'({p1_rvalid, p0_rvalid}), (port == 0) ? 32'd1 : 32'd2);
            chk("resp_busy", 32'(busy), 32'd1);
            rd = (port == 0) ? p0_rdata : p1_rdata;
            chk("resp_rdata", rd, exp_rd);
            chk("other_rdata_held", (port == 0) ? p1_rdata : p0_rdata, last_rd[1-port]);
            last_rd[port] = exp_rd;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t          vecs [9];
        int            gq [$];
        int            lat, rv0, rv1;
        logic [DW-1:0] rd;

        for (int i = 0; i < int'(DEPTH); i++) shadow[i] = init_word(i);
        model_reset();
        rst = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 32'({busy, mem_write, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_w_data", m_w_data, 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_ctrl", 32'({busy, mem_write, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}), 32'd0);
            chk("idle_m_addr", m_addr, 32'd0);
        end

        // Directed vector table
        vecs[0] = mk(0, 1'b1, 32'd5,   32'hDEAD_BEEF, 32'h0);
        vecs[1] = mk(0, 1'b0, 32'd5,   32'h0,         32'hDEAD_BEEF);
        vecs[2] = mk(1, 1'b1, 32'd127, 32'h0000_1234, 32'h0);
        vecs[3] = mk(0, 1'b0, 32'd127, 32'h0,         32'h0000_1234);
        vecs[4] = mk(1, 1'b0, 32'd5,   32'h0,         32'hDEAD_BEEF);
        vecs[5] = mk(1, 1'b1, 32'd0,   32'hA5A5_A5A5, 32'h0);
        vecs[6] = mk(0, 1'b0, 32'd0,   32'h0,         32'hA5A5_A5A5);
        vecs[7] = mk(0, 1'b1, 32'd5,   32'hCAFE_F00D, 32'h0);
        vecs[8] = mk(1, 1'b0, 32'd5,   32'h0,         32'hCAFE_F00D);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            set_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            serve(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
            chk("vec_gnt_latency", 32'(lat), 32'd1);
            if (!vecs[i].we) chk("vec_rdata", rd, vecs[i].exp_rdata);
        end

        // Both requesters hold reads from reset release: grants must alternate
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 1'b0, 32'd3, 32'h0);
        set_req(1, 1'b0, 32'd4, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        rv0 = 0; rv1 = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (p0_gnt) gq.push_back(0);
            if (p1_gnt) gq.push_back(1);
            chk("fair_rvalid_overlap", 32'(p0_rvalid && p1_rvalid), 32'd0);
            if (p0_rvalid) begin rv0++; chk("fair_p0_rdata", p0_rdata, shadow[3]); end
            if (p1_rvalid) begin rv1++; chk("fair_p1_rdata", p1_rdata, shadow[4]); end
        end
        drop_req(0);
        drop_req(1);
        chk("fair_grant_count", 32'(gq.size()), 32'd4);
        chk("fair_rvalid_counts", 32'({rv0[7:0], rv1[7:0]}), 32'h0202);
        for (int k = 0; k < gq.size() && k < 4; k++) chk("fair_grant_order", 32'(gq[k]), 32'(k % 2));
        fav = 0;
        last_rd[0] = shadow[3];
        last_rd[1] = shadow[4];

        // Reset asserted during RESP of a p0 read
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd5, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_gnt", 32'(p0_gnt), 32'd1);
        @(posedge clk); #1;
        drop_req(0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ctrl", 32'({busy, mem_write, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}), 32'd0);
        chk("midrst_m_addr", m_addr, 32'd0);
        chk("midrst_p0_rdata", p0_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("midrst_quiet", 32'({busy, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}), 32'd0);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd5, 32'h0);
        serve(0, 1'b0, 32'd5, 32'h0, lat, rd);
        chk("reissue_latency", 32'(lat), 32'd1);
        chk("reissue_rdata", rd, 32'hCAFE_F00D);

`ifdef MEM_ARB_BOUND_CHECK_EN
        // Out-of-range accesses: write blocked, read returns zero
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'd200, 32'h55AA_55AA);
        @(negedge clk);
        @(negedge clk);
        chk("bc_w_gnt_err", 32'({p1_err, p0_err, p1_gnt, p0_gnt}), 32'b0101);
        chk("bc_w_mem_write", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        drop_req(0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd200, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("bc_r_gnt_err", 32'({p1_err, p0_err, p1_gnt, p0_gnt}), 32'b0101);
        @(posedge clk); #1;
        drop_req(0);
        @(negedge clk);
        chk("bc_r_rvalid", 32'(p0_rvalid), 32'd1);
        chk("bc_r_rdata", p0_rdata, 32'd0);
        last_rd[0] = '0;
        fav = 1;
`endif

        // Randomized traffic against the transaction-level model
        for (int it = 0; it < 60; it++) begin
            int            mask, w;
            logic          rwe [2];
            logic [AW-1:0] raddr [2];
            logic [DW-1:0] rwdata [2];
            mask = int'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                rwe[p]    = 1'($urandom_range(0, 1));
                raddr[p]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 127))
                                                        : 32'($urandom_range(0, 7));
                rwdata[p] = $urandom;
            end
            @(posedge clk); #1;
            if ((mask & 1) != 0) set_req(0, rwe[0], raddr[0], rwdata[0]);
            if ((mask & 2) != 0) set_req(1, rwe[1], raddr[1], rwdata[1]);
            w = (mask == 3) ? fav : ((mask == 2) ? 1 : 0);
            serve(w, rwe[w], raddr[w], rwdata[w], lat, rd);
            chk("rand_gnt_latency", 32'(lat), 32'd1);
            if (mask == 3) begin
                serve(1 - w, rwe[1-w], raddr[1-w], rwdata[1-w], lat, rd);
                chk("rand_loser_latency", 32'(lat), 32'd1);
            end
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
